// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;

  // Counter must hold 0..DataLength.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Widest supported quotient; callers slice to DataLength.
  localparam logic [63:0] DBZ_QUOT = '1;

endpackage

// File: rtl/restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract D
// on a ripple borrow chain, keep the difference only when it is non-negative.
module restore_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] r,
  input  logic         bit_in,
  input  logic [W-1:0] d,
  output logic [W:0]   r_next,
  output logic         q_bit
);

  logic [W:0] r_sh, sub_b, diff;
  logic [W:0] carry;

  assign r_sh     = {r, bit_in};
  assign sub_b    = ~{1'b0, d};
  assign carry[0] = 1'b1;

  // Subtraction as r_sh + ~D + 1, same cell the ALU adder uses.
  for (genvar i = 0; i <= W; i++) begin : g_rca
    assign diff[i] = r_sh[i] ^ sub_b[i] ^ carry[i];
    if (i < W) begin : g_cy
      assign carry[i+1] = (r_sh[i] & sub_b[i]) | (carry[i] & (r_sh[i] ^ sub_b[i]));
    end
  end

  assign q_bit  = ~diff[W];
  assign r_next = q_bit ? diff : r_sh;

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, Start/Busy/Done
// handshake. Define SIGNED_DIVIDE_EN for two's-complement operands.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DataLength = 4
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic [DataLength-1:0] Dividend,
  input  logic [DataLength-1:0] Divisor,
  output logic                  Busy,
  output logic                  Done,
  output logic [DataLength-1:0] Quotient,
  output logic [DataLength-1:0] Remainder,
  output logic                  DivByZero
);

  localparam int N  = DataLength;
  localparam int CW = cnt_w(DataLength);

  div_state_e      state_q, state_d;
  logic [N:0]      r_q;
  logic [N-1:0]    q_q, d_q;
  logic [CW-1:0]   cnt_q;
  logic            done_q, dbz_q;
  logic [N-1:0]    quot_q, rem_q;

  logic            accept, div_zero, last;
  logic [N:0]      r_nxt;
  logic            q_bit;
  logic [N-1:0]    q_nxt;
  logic [N-1:0]    a_mag, b_mag, res_q, res_r;
  logic            unused_r_msb;

  assign accept   = Start && (state_q != RUN);
  assign div_zero = (Divisor == '0);
  assign last     = (state_q == RUN) && (cnt_q == CW'(N - 1));
  // Top bit of R is rebuilt from R[N-1] every step, so it is never read back.
  assign unused_r_msb = r_q[N];

  restore_step #(.W(N)) u_step (
    .r      (r_q[N-1:0]),
    .bit_in (q_q[N-1]),
    .d      (d_q),
    .r_next (r_nxt),
    .q_bit  (q_bit)
  );

  assign q_nxt = {q_q[N-2:0], q_bit};

`ifdef SIGNED_DIVIDE_EN
  logic qneg_q, rneg_q;

  // Iterate on magnitudes; restore signs when the result loads.
  assign a_mag = Dividend[N-1] ? -Dividend : Dividend;
  assign b_mag = Divisor[N-1]  ? -Divisor  : Divisor;
  assign res_q = qneg_q ? -q_nxt : q_nxt;
  assign res_r = rneg_q ? -r_nxt[N-1:0] : r_nxt[N-1:0];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (accept && !div_zero) begin
      qneg_q <= Dividend[N-1] ^ Divisor[N-1];
      rneg_q <= Dividend[N-1];
    end
  end
`else
  assign a_mag = Dividend;
  assign b_mag = Divisor;
  assign res_q = q_nxt;
  assign res_r = r_nxt[N-1:0];
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    Busy    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (Start)                state_d = div_zero ? DONE : RUN;
        else if (state_q == DONE) state_d = IDLE;
      end
      RUN: begin
        Busy = 1'b1;
        if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (div_zero) begin
          quot_q <= DBZ_QUOT[N-1:0];
          rem_q  <= Dividend;
          dbz_q  <= 1'b1;
          done_q <= 1'b1;
        end else begin
          r_q   <= '0;
          q_q   <= a_mag;
          d_q   <= b_mag;
          cnt_q <= '0;
        end
      end else if (state_q == RUN) begin
        r_q   <= r_nxt;
        q_q   <= q_nxt;
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          quot_q <= res_q;
          rem_q  <= res_r;
          dbz_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Quotient  = quot_q;
  assign Remainder = rem_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (DataLength=4): directed cases
// plus randomized operands against an arithmetic reference model.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         Clock, Reset_n, Start;
  logic [W-1:0] Dividend, Divisor;
  logic         Busy, Done, DivByZero;
  logic [W-1:0] Quotient, Remainder;

  int checks = 0;
  int fails  = 0;
  logic [W-1:0] prev_q, prev_r;

  seq_restoring_divider #(.DataLength(W)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Reference: plain integer division with the divide-by-zero convention.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    int qi, ri, sa, sb;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
`ifdef SIGNED_DIVIDE_EN
      sa = $signed(a);
      sb = $signed(b);
`else
      sa = int'(a);
      sb = int'(b);
`endif
      qi = sa / sb;
      ri = sa % sb;
      q  = qi[W-1:0];
      r  = ri[W-1:0];
      dz = 1'b0;
    end
  endtask

  // Issue one divide and follow it cycle by cycle to the Done pulse.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input bit pulse_mid);
    Start = 1'b1; Dividend = a; Divisor = b;
    tick();
    Start = 1'b0;
    if (b != 0) begin
      for (int k = 0; k < W; k++) begin
        chk("busy_run", Busy, 1'b1);
        chk("done_run", Done, 1'b0);
        chk("quot_hold", Quotient, prev_q);
        chk("rem_hold", Remainder, prev_r);
        if (pulse_mid && k == 1) begin
          Start = 1'b1; Dividend = W'($urandom); Divisor = W'($urandom_range(1, 15));
        end else begin
          Start = 1'b0;
        end
        tick();
      end
    end
    chk("done", Done, 1'b1);
    chk("busy_done", Busy, 1'b0);
    chk("quot", Quotient, eq);
    chk("rem", Remainder, er);
    chk("dbz", DivByZero, edz);
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic idle_check();
    tick();
    chk("done_pulse", Done, 1'b0);
    chk("busy_idle", Busy, 1'b0);
  endtask

  initial begin
    logic [W-1:0] a, b, eq, er;
    logic edz;

    Reset_n = 1'b0; Start = 1'b0; Dividend = '0; Divisor = '0;
    prev_q = '0; prev_r = '0;
    tick(); tick();
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_quot", Quotient, 0);
    chk("rst_rem", Remainder, 0);
    chk("rst_dbz", DivByZero, 1'b0);
    Reset_n = 1'b1;
    tick();

`ifndef SIGNED_DIVIDE_EN
    run_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b0);
    idle_check();
    run_div(4'd7, 4'd0, 4'hF, 4'd7, 1'b1, 1'b0);
    idle_check();
    // Back-to-back: second Start arrives during the DONE cycle.
    run_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0);
    run_div(4'd9, 4'd4, 4'd2, 4'd1, 1'b0, 1'b0);
    idle_check();
    run_div(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 1'b1);
    idle_check();
`else
    run_div(4'h9, 4'd2, 4'hD, 4'hF, 1'b0, 1'b0);
    idle_check();
    run_div(4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 1'b0);
    idle_check();
    run_div(4'd7, 4'd0, 4'hF, 4'd7, 1'b1, 1'b0);
    idle_check();
`endif

    // Reset during the second RUN cycle discards the divide.
    Start = 1'b1; Dividend = 4'd13; Divisor = 4'd3;
    tick();
    Start = 1'b0;
    tick();
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", Busy, 1'b0);
    chk("mid_rst_done", Done, 1'b0);
    chk("mid_rst_quot", Quotient, 0);
    chk("mid_rst_rem", Remainder, 0);
    chk("mid_rst_dbz", DivByZero, 1'b0);
    prev_q = '0; prev_r = '0;
    tick();
    Reset_n = 1'b1;
    tick();
    run_div(4'd6, 4'd2, 4'd3, 4'd0, 1'b0, 1'b0);
    idle_check();

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      model(a, b, eq, er, edz);
      run_div(a, b, eq, er, edz, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 0) idle_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
